camera_sequencer: RTL and testbench

Frame-level controller for the pixel array. Sequences erase, exposure and row-by-row readout, and drives the row address that feeds the gate-level row decoder built from the AND3/NAND/NAND8/INVERT cells. Holds a programmable exposure time adjusted by up/down requests between frames. All outputs are Moore outputs decoded from registered state.

---
 rtl/camera_pkg.sv | 21 ++
 rtl/exposure_reg.sv | 42 ++++
 rtl/camera_sequencer.sv | 128 ++++++++++++
 tb/tb_camera_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera frame sequencer.
package camera_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPOSE = 2'd1,
        SETTLE = 2'd2,
        SAMPLE = 2'd3
    } state_e;

    localparam int unsigned ROWS_DEF        = 4;
    localparam int unsigned EXP_MIN_DEF     = 2;
    localparam int unsigned EXP_MAX_DEF     = 30;
    localparam int unsigned EXP_DEFAULT_DEF = 16;

    // Bits needed to index n distinct values, never less than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/exposure_reg.sv
// Saturating up/down exposure-time register, adjustable only while enabled.
module exposure_reg
    import camera_pkg::*;
#(
    parameter int unsigned MIN     = EXP_MIN_DEF,
    parameter int unsigned MAX     = EXP_MAX_DEF,
    parameter int unsigned DEFAULT = EXP_DEFAULT_DEF,
    parameter int unsigned W       = width_for(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // One step per enabled cycle; simultaneous inc and dec cancel out.
    always_comb begin
        value_d = value_q;
        if (en_i && inc_i && !dec_i && (value_q < W'(MAX))) begin
            value_d = value_q + W'(1);
        end else if (en_i && dec_i && !inc_i && (value_q > W'(MIN))) begin
            value_d = value_q - W'(1);
        end
    end

    // Value register, returns to the power-on exposure on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= W'(DEFAULT);
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/camera_sequencer.sv
// Frame controller: erase, timed exposure, then a settle/sample pair per row.
module camera_sequencer
    import camera_pkg::*;
#(
    parameter int unsigned ROWS        = ROWS_DEF,
    parameter int unsigned EXP_MIN     = EXP_MIN_DEF,
    parameter int unsigned EXP_MAX     = EXP_MAX_DEF,
    parameter int unsigned EXP_DEFAULT = EXP_DEFAULT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic                        exp_inc,
    input  logic                        exp_dec,
    output logic                        erase,
    output logic                        expose,
    output logic                        row_sel,
    output logic                        adc,
    output logic [width_for(ROWS)-1:0]  row_addr,
    output logic                        busy
);

    localparam int unsigned RW = width_for(ROWS);
    localparam int unsigned EW = width_for(EXP_MAX + 1);

    state_e        state_q, state_d;
    logic [EW-1:0] cnt_q,   cnt_d;
    logic [RW-1:0] row_q,   row_d;
    logic [EW-1:0] exp_time;

    exposure_reg #(
        .MIN     (EXP_MIN),
        .MAX     (EXP_MAX),
        .DEFAULT (EXP_DEFAULT),
        .W       (EW)
    ) u_exposure_reg (
        .clk     (clk),
        .reset   (reset),
        .en_i    (state_q == IDLE),
        .inc_i   (exp_inc),
        .dec_i   (exp_dec),
        .value_o (exp_time)
    );

    // Next state, exposure countdown and row counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                row_d = '0;
                if (init) begin
                    state_d = EXPOSE;
                    cnt_d   = exp_time;
                end
            end
            EXPOSE: begin
                if (cnt_q <= EW'(1)) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - EW'(1);
                end
            end
            SETTLE: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                // Row address only moves when leaving SAMPLE, so it is stable
                // across the whole settle/sample pair of each row.
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = IDLE;
                    row_d   = '0;
                end else begin
                    state_d = SETTLE;
                    row_d   = row_q + RW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    // State, countdown and row registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    // Moore output decode from the registered state only.
    always_comb begin
        erase   = 1'b0;
        expose  = 1'b0;
        row_sel = 1'b0;
        adc     = 1'b0;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                erase = 1'b1;
                busy  = 1'b0;
            end
            EXPOSE: expose = 1'b1;
            SETTLE: row_sel = 1'b1;
            SAMPLE: begin
                row_sel = 1'b1;
                adc     = 1'b1;
            end
            default: begin
                erase = 1'b1;
                busy  = 1'b0;
            end
        endcase
    end

    assign row_addr = row_q;

endmodule

// File: tb/tb_camera_sequencer.sv
// Self-checking bench for camera_sequencer against a frame-timing model.
module tb_camera_sequencer;

    localparam int ROWS        = 4;
    localparam int EXP_MIN     = 2;
    localparam int EXP_MAX     = 30;
    localparam int EXP_DEFAULT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic       exp_inc = 1'b0;
    logic       exp_dec = 1'b0;
    logic       erase, expose, row_sel, adc, busy;
    logic [1:0] row_addr;

    int vectors = 0;
    int errors  = 0;

    // Reference model: frame position relative to the init edge.
    bit m_busy = 0;
    int m_t    = 0;
    int m_E    = 0;
    int m_exp  = EXP_DEFAULT;

    int run = 0;
    bit prev_exp = 0;

    camera_sequencer #(
        .ROWS        (ROWS),
        .EXP_MIN     (EXP_MIN),
        .EXP_MAX     (EXP_MAX),
        .EXP_DEFAULT (EXP_DEFAULT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .exp_inc  (exp_inc),
        .exp_dec  (exp_dec),
        .erase    (erase),
        .expose   (expose),
        .row_sel  (row_sel),
        .adc      (adc),
        .row_addr (row_addr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 0;
        m_t      = 0;
        m_exp    = EXP_DEFAULT;
        run      = 0;
        prev_exp = 0;
    endtask

    task automatic model_edge(input bit i, input bit inc, input bit dec);
        if (m_busy) begin
            m_t++;
            if (m_t > m_E + 2 * ROWS) m_busy = 0;
        end else begin
            if (i) begin
                m_busy = 1;
                m_t    = 1;
                m_E    = m_exp;
            end
            if (inc && !dec) m_exp = (m_exp < EXP_MAX) ? m_exp + 1 : EXP_MAX;
            if (dec && !inc) m_exp = (m_exp > EXP_MIN) ? m_exp - 1 : EXP_MIN;
        end
    endtask

    task automatic check_outputs();
        int e_erase, e_expose, e_rsel, e_adc, e_row, u;
        e_erase = 0; e_expose = 0; e_rsel = 0; e_adc = 0; e_row = 0;
        if (!m_busy) begin
            e_erase = 1;
        end else if (m_t <= m_E) begin
            e_expose = 1;
        end else begin
            u      = m_t - m_E - 1;
            e_rsel = 1;
            e_row  = u / 2;
            e_adc  = u % 2;
        end
        check_eq("erase",    int'(erase),    e_erase);
        check_eq("expose",   int'(expose),   e_expose);
        check_eq("row_sel",  int'(row_sel),  e_rsel);
        check_eq("adc",      int'(adc),      e_adc);
        check_eq("row_addr", int'(row_addr), e_row);
        check_eq("busy",     int'(busy),     int'(m_busy));
        check_eq("overlap",
                 int'((erase & (expose | row_sel | adc)) | (expose & (row_sel | adc))), 0);
        check_eq("row_range", int'(int'(row_addr) < ROWS), 1);
    endtask

    task automatic cyc(input bit i, input bit inc, input bit dec);
        init    = i;
        exp_inc = inc;
        exp_dec = dec;
        @(posedge clk);
        model_edge(i, inc, dec);
        #1;
        check_outputs();
        if (expose) begin
            run++;
        end else if (prev_exp) begin
            check_eq("exp_len", run, m_E);
            run = 0;
        end
        prev_exp = expose;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    initial begin
        // Power-on reset, held across edges.
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        idle_cycles(5);

        // Default frame: 16 expose cycles then 4 row pairs.
        cyc(1, 0, 0);
        idle_cycles(30);

        // Saturate low, then a minimum-length frame.
        for (int i = 0; i < 20; i++) cyc(0, 0, 1);
        cyc(1, 0, 0);
        idle_cycles(12);

        // Saturate high, then a maximum-length frame.
        for (int i = 0; i < 40; i++) cyc(0, 1, 0);
        cyc(1, 0, 0);
        idle_cycles(40);

        // Back to 16, then init with inc in the same cycle: 16 now, 17 next.
        for (int i = 0; i < 14; i++) cyc(0, 0, 1);
        cyc(1, 1, 0);
        idle_cycles(26);
        cyc(1, 0, 0);
        idle_cycles(27);

        // inc and dec together leave exposure unchanged.
        for (int i = 0; i < 5; i++) cyc(0, 1, 1);
        cyc(1, 0, 0);
        idle_cycles(27);

        // Random stimulus including inputs toggling mid-frame.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(7) == 0), $urandom_range(1), $urandom_range(1));
        end
        idle_cycles(40);

        // Asynchronous reset in the middle of exposure.
        cyc(1, 0, 0);
        idle_cycles(4);
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        idle_cycles(3);

        // init held high: back-to-back frames with one erase cycle between.
        for (int i = 0; i < 80; i++) cyc(1, 0, 0);
        idle_cycles(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
